// File: rtl/rot_enc_pkg.sv
// Shared types and constants for the multi-channel quadrature encoder peripheral.
// Register offsets, CTRL bit positions, decode/mode enums and bus helpers.
package rot_enc_pkg;

    localparam logic [1:0] RegCount = 2'd0;
    localparam logic [1:0] RegIndex = 2'd1;
    localparam logic [1:0] RegVel   = 2'd2;
    localparam logic [1:0] RegCtrl  = 2'd3;

    localparam int unsigned CtrlEn    = 0;
    localparam int unsigned CtrlInv   = 3;
    localparam int unsigned CtrlZclr  = 4;
    localparam int unsigned CtrlErr   = 8;
    localparam int unsigned CtrlZseen = 9;

    typedef enum logic [1:0] {
        ModeX4  = 2'd0,
        ModeX2  = 2'd1,
        ModeX1  = 2'd2,
        ModeX4b = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        StepNone = 2'd0,
        StepUp   = 2'd1,
        StepDown = 2'd2,
        StepErr  = 2'd3
    } step_e;

    typedef enum logic {
        StIdle = 1'b0,
        StAck  = 1'b1
    } bus_st_e;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic [31:0] sext32(input logic [31:0] v, input int unsigned w);
        logic signed [31:0] t;
        t = signed'(v << (32 - w));
        return t >>> (32 - w);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/rot_enc_chan.sv
// One encoder channel: A/B/Z synchroniser and glitch filter, quadrature decoder,
// position counter, index latch, velocity sample and sticky flags.
module rot_enc_chan
    import rot_enc_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DELAY = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        tick_i,
    input  logic        a_i,
    input  logic        b_i,
    input  logic        z_i,
    input  logic        wr_i,
    input  logic [1:0]  reg_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rd_o
);

    localparam int unsigned FW = (DELAY > 1) ? $clog2(DELAY) : 1;
    localparam int unsigned WW = $clog2(DELAY + 5);

    // Bit order for the three input paths: 0 = A, 1 = B, 2 = Z.
    logic [2:0]       s1_q, s2_q, flt_q, flt_d, prev_q;
    logic [FW-1:0]    fcnt_q [3];
    logic [FW-1:0]    fcnt_d [3];
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic             primed_q, primed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, idx_q, idx_d, vel_q, vel_d, last_q, last_d;
    logic             en_q, en_d, inv_q, inv_d, zclr_q, zclr_d;
    logic             err_q, err_d, zseen_q, zseen_d;
    mode_e            mode_q, mode_d;
    step_e            step;
    logic             a_chg, b_chg, up, hit, ev, z_rise;

    always_comb begin
        flt_d = flt_q;
        for (int i = 0; i < 3; i++) begin
            fcnt_d[i] = '0;
            if (s2_q[i] != flt_q[i]) begin
                if (fcnt_q[i] == FW'(DELAY - 1)) flt_d[i] = s2_q[i];
                else fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    // Hold off decoding until the filters have settled on the levels present at reset.
    always_comb begin
        primed_d = primed_q | (wcnt_q == WW'(DELAY + 4));
        wcnt_d   = primed_q ? wcnt_q : wcnt_q + 1'b1;
    end

    always_comb begin
        a_chg = flt_q[0] ^ prev_q[0];
        b_chg = flt_q[1] ^ prev_q[1];
        up    = (prev_q[0] == flt_q[1]) ^ inv_q;
        case (mode_q)
            ModeX2:  hit = a_chg;
            ModeX1:  hit = a_chg & flt_q[0];
            default: hit = a_chg | b_chg;
        endcase
        step = StepNone;
        if (a_chg && b_chg) step = StepErr;
        else if (hit)       step = up ? StepUp : StepDown;
        ev     = en_q & primed_q;
        z_rise = ev & flt_q[2] & ~prev_q[2];
    end

    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        vel_d   = vel_q;
        last_d  = last_q;
        en_d    = en_q;
        mode_d  = mode_q;
        inv_d   = inv_q;
        zclr_d  = zclr_q;
        err_d   = err_q;
        zseen_d = zseen_q;

        if (ev && step == StepUp)        cnt_d = cnt_q + 1'b1;
        else if (ev && step == StepDown) cnt_d = cnt_q - 1'b1;

        if (wr_i && reg_i == RegCtrl) begin
            if (wstrb_i[0]) begin
                en_d   = wdata_i[CtrlEn];
                mode_d = mode_e'(wdata_i[2:1]);
                inv_d  = wdata_i[CtrlInv];
                zclr_d = wdata_i[CtrlZclr];
            end
            if (wstrb_i[1]) begin
                if (wdata_i[CtrlErr])   err_d   = 1'b0;
                if (wdata_i[CtrlZseen]) zseen_d = 1'b0;
            end
        end

        // New events are applied after W1C so a coincident event keeps its flag set.
        if (ev && step == StepErr) err_d = 1'b1;
        if (z_rise) begin
            idx_d   = cnt_q;
            zseen_d = 1'b1;
            if (zclr_q) cnt_d = '0;
        end
        if (wr_i && reg_i == RegCount) begin
            cnt_d = CNT_W'(merge_bytes(sext32(32'(cnt_q), CNT_W), wdata_i, wstrb_i));
        end
        if (tick_i && en_q) begin
            vel_d  = cnt_q - last_q;
            last_d = cnt_q;
        end
    end

    always_comb begin
        rd_o = '0;
        unique case (reg_i)
            RegCount: rd_o = sext32(32'(cnt_q), CNT_W);
            RegIndex: rd_o = sext32(32'(idx_q), CNT_W);
            RegVel:   rd_o = sext32(32'(vel_q), CNT_W);
            RegCtrl:  rd_o = {22'd0, zseen_q, err_q, 3'd0, zclr_q, inv_q, mode_q, en_q};
            default:  rd_o = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= '0;
            s2_q     <= '0;
            flt_q    <= '0;
            prev_q   <= '0;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= '0;
            wcnt_q   <= '0;
            primed_q <= 1'b0;
            cnt_q    <= '0;
            idx_q    <= '0;
            vel_q    <= '0;
            last_q   <= '0;
            en_q     <= 1'b0;
            mode_q   <= ModeX4;
            inv_q    <= 1'b0;
            zclr_q   <= 1'b0;
            err_q    <= 1'b0;
            zseen_q  <= 1'b0;
        end else begin
            s1_q     <= {z_i, b_i, a_i};
            s2_q     <= s1_q;
            flt_q    <= flt_d;
            prev_q   <= flt_q;
            for (int i = 0; i < 3; i++) fcnt_q[i] <= fcnt_d[i];
            wcnt_q   <= wcnt_d;
            primed_q <= primed_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            vel_q    <= vel_d;
            last_q   <= last_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            inv_q    <= inv_d;
            zclr_q   <= zclr_d;
            err_q    <= err_d;
            zseen_q  <= zseen_d;
        end
    end

endmodule

// File: rtl/rot_enc_multi.sv
// Multi-channel quadrature encoder peripheral: valid/ready bus slave, register
// decode, read mux and the velocity window divider shared by all channels.
module rot_enc_multi
    import rot_enc_pkg::*;
#(
    parameter int unsigned CH      = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DELAY   = 4,
    parameter int unsigned VEL_DIV = 100000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          valid_i,
    output logic          ready_o,
    input  logic [3:0]    wstrb_i,
    input  logic [31:0]   addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o,
    input  logic [CH-1:0] a_i,
    input  logic [CH-1:0] b_i,
    input  logic [CH-1:0] z_i
);

    localparam int unsigned DW = $clog2(VEL_DIV);

    bus_st_e       st_q, st_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [DW-1:0] div_q, div_d;
    logic          tick, accept;
    logic [3:0]    ch_sel;
    logic [31:0]   rd_all [16];
    logic          addr_unused;

    assign addr_unused = ^{addr_i[31:8], addr_i[1:0]};
    assign ch_sel      = addr_i[7:4];
    assign accept      = (st_q == StIdle) & valid_i;
    assign tick        = (div_q == DW'(VEL_DIV - 1));
    assign ready_o     = (st_q == StAck);
    assign rdata_o     = rdata_q;

    always_comb begin
        st_d    = st_q;
        rdata_d = '0;
        unique case (st_q)
            StIdle: if (accept) begin
                st_d = StAck;
                if (wstrb_i == 4'd0) rdata_d = rd_all[ch_sel];
            end
            StAck:   st_d = StIdle;
            default: st_d = StIdle;
        endcase
        div_d = tick ? '0 : div_q + 1'b1;
    end

    // Slots at or above CH read as zero and swallow writes.
    for (genvar gi = 0; gi < 16; gi++) begin : g_ch
        if (gi < CH) begin : g_on
            rot_enc_chan #(
                .CNT_W (CNT_W),
                .DELAY (DELAY)
            ) u_chan (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .tick_i  (tick),
                .a_i     (a_i[gi]),
                .b_i     (b_i[gi]),
                .z_i     (z_i[gi]),
                .wr_i    (accept && (|wstrb_i) && (ch_sel == 4'(gi))),
                .reg_i   (addr_i[3:2]),
                .wstrb_i (wstrb_i),
                .wdata_i (wdata_i),
                .rd_o    (rd_all[gi])
            );
        end else begin : g_off
            assign rd_all[gi] = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q    <= StIdle;
            rdata_q <= '0;
            div_q   <= '0;
        end else begin
            st_q    <= st_d;
            rdata_q <= rdata_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: tb/tb_rot_enc_multi.sv
// Bench for rot_enc_multi: directed scenarios plus a randomized walk checked
// against a position/step model of the encoder.
module tb_rot_enc_multi;

    localparam int unsigned CH      = 4;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned DELAY   = 4;
    localparam int unsigned VEL_DIV = 100;
    localparam logic [1:0]  R_CNT   = 2'd0;
    localparam logic [1:0]  R_IDX   = 2'd1;
    localparam logic [1:0]  R_VEL   = 2'd2;
    localparam logic [1:0]  R_CTL   = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid, ready;
    logic [3:0]    wstrb;
    logic [31:0]   addr, wdata, rdata;
    logic [CH-1:0] a, b, z;

    always #5 clk = ~clk;

    rot_enc_multi #(
        .CH      (CH),
        .CNT_W   (CNT_W),
        .DELAY   (DELAY),
        .VEL_DIV (VEL_DIV)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid),
        .ready_o (ready),
        .wstrb_i (wstrb),
        .addr_i  (addr),
        .wdata_i (wdata),
        .rdata_o (rdata),
        .a_i     (a),
        .b_i     (b),
        .z_i     (z)
    );

    // Model: quadrature phase index along the forward (A leads B) sequence.
    bit         seq_a [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit         seq_b [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int         pos   [4];
    logic [7:0] mcnt  [4];
    int         mmode [4];
    bit         minv  [4];
    bit         men   [4];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [7:0] v);
        return {{24{v[7]}}, v};
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input int ch, input logic [1:0] rg, input logic [3:0] strb,
                            input logic [31:0] wd, output logic [31:0] rd);
        bit ok;
        ok    = 1'b0;
        rd    = '0;
        addr  = {24'd0, 4'(ch), rg, 2'b00};
        wstrb = strb;
        wdata = wd;
        valid = 1'b1;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                ok = 1'b1;
                rd = rdata;
            end
        end
        valid = 1'b0;
        wstrb = '0;
        check_val("bus_ack", {31'd0, ok}, 32'd1);
    endtask

    task automatic rd_reg(input int ch, input logic [1:0] rg, output logic [31:0] v);
        bus_xfer(ch, rg, 4'h0, 32'd0, v);
    endtask

    task automatic wr_reg(input int ch, input logic [1:0] rg, input logic [31:0] v);
        logic [31:0] dummy;
        bus_xfer(ch, rg, 4'hF, v, dummy);
    endtask

    task automatic cfg(input int ch, input bit en, input int mode, input bit inv, input bit zclr);
        wr_reg(ch, R_CTL, {27'd0, zclr, inv, 2'(mode), en});
        men[ch]   = en;
        mmode[ch] = mode;
        minv[ch]  = inv;
    endtask

    task automatic set_count(input int ch, input logic [7:0] v);
        wr_reg(ch, R_CNT, sx(v));
        mcnt[ch] = v;
    endtask

    task automatic model_step(input int ch, input int dir);
        int np;
        bit counts;
        int d;
        np = (pos[ch] + dir + 4) % 4;
        case (mmode[ch])
            1:       counts = (seq_a[np] != seq_a[pos[ch]]);
            2:       counts = seq_a[np] && !seq_a[pos[ch]];
            default: counts = 1'b1;
        endcase
        d = minv[ch] ? -dir : dir;
        if (men[ch] && counts) mcnt[ch] = mcnt[ch] + 8'(d);
        pos[ch] = np;
    endtask

    task automatic drive_pos(input int ch);
        a[ch] = seq_a[pos[ch]];
        b[ch] = seq_b[pos[ch]];
    endtask

    task automatic quad_step(input int ch, input int dir, input int hold);
        model_step(ch, dir);
        drive_pos(ch);
        idle(hold);
    endtask

    task automatic chk_count(input string tag, input int ch);
        logic [31:0] v;
        rd_reg(ch, R_CNT, v);
        check_val(tag, v, sx(mcnt[ch]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  midx;
        rst_n = 1'b0;
        valid = 1'b0;
        wstrb = '0;
        addr  = '0;
        wdata = '0;
        a = '0;
        b = '0;
        z = '0;
        for (int i = 0; i < 4; i++) begin
            pos[i] = 0; mcnt[i] = '0; mmode[i] = 0; minv[i] = 0; men[i] = 0;
        end
        idle(3);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        check_val("rst_rdata", rdata, 32'd0);
        rst_n = 1'b1;
        idle(20);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_reg(c, 2'(r), v);
                check_val("rst_reg", v, 32'd0);
            end
        end

        // x4 / x1 / x2 decode on channel 0
        cfg(0, 1, 0, 0, 0);
        repeat (40) quad_step(0, 1, 20);
        chk_count("x4_fwd", 0);
        repeat (40) quad_step(0, -1, 20);
        chk_count("x4_rev", 0);
        cfg(0, 1, 2, 0, 0);
        repeat (40) quad_step(0, 1, 20);
        chk_count("x1_fwd", 0);
        set_count(0, 8'd0);
        cfg(0, 1, 1, 0, 0);
        repeat (40) quad_step(0, 1, 20);
        chk_count("x2_fwd", 0);

        // Glitch filter, x1 so a full pulse nets exactly one count
        cfg(0, 1, 2, 0, 0);
        set_count(0, 8'd0);
        for (int len = 2; len <= 3; len++) begin
            a[0] = 1'b1;
            idle(len);
            a[0] = 1'b0;
            idle(20);
            chk_count(len == 2 ? "glitch2" : "glitch3", 0);
        end
        a[0] = 1'b1;
        idle(4);
        a[0] = 1'b0;
        model_step(0, 1);
        model_step(0, -1);
        idle(20);
        chk_count("pulse4", 0);

        // Wrap at CNT_W = 8
        cfg(0, 1, 0, 0, 0);
        set_count(0, 8'd127);
        quad_step(0, 1, 20);
        rd_reg(0, R_CNT, v);
        check_val("wrap_up", v, sx(mcnt[0]));
        set_count(0, 8'd0);
        quad_step(0, -1, 20);
        rd_reg(0, R_CNT, v);
        check_val("wrap_dn", v, sx(mcnt[0]));

        // Index latch and Z clear
        set_count(0, 8'd55);
        z[0] = 1'b1;
        idle(20);
        rd_reg(0, R_IDX, v);
        check_val("index", v, sx(mcnt[0]));
        rd_reg(0, R_CTL, v);
        check_val("zseen", v, 32'h201);
        z[0] = 1'b0;
        idle(20);
        cfg(0, 1, 0, 0, 1);
        midx = mcnt[0];
        z[0] = 1'b1;
        model_step(0, 1);
        mcnt[0] = '0;
        drive_pos(0);
        idle(20);
        chk_count("zclr_step", 0);
        rd_reg(0, R_IDX, v);
        check_val("zclr_idx", v, sx(midx));
        z[0] = 1'b0;
        idle(20);
        wr_reg(0, R_CTL, 32'h201);
        rd_reg(0, R_CTL, v);
        check_val("zseen_w1c", v, 32'h001);

        // Illegal transition: both bits flip together
        pos[0] = (pos[0] + 2) % 4;
        drive_pos(0);
        idle(20);
        chk_count("err_cnt", 0);
        rd_reg(0, R_CTL, v);
        check_val("err_set", v, 32'h101);
        wr_reg(0, R_CTL, 32'h101);
        rd_reg(0, R_CTL, v);
        check_val("err_w1c", v, 32'h001);
        pos[0] = (pos[0] + 2) % 4;
        drive_pos(0);
        repeat (6) @(posedge clk);
        #1;
        wr_reg(0, R_CTL, 32'h101);
        idle(10);
        rd_reg(0, R_CTL, v);
        check_val("err_coinc", v, 32'h101);
        chk_count("err_cnt2", 0);

        // Unpopulated channel, ready pulse width
        rd_reg(7, R_CNT, v);
        check_val("ch7_rd", v, 32'd0);
        idle(1);
        check_val("ready_pulse", {31'd0, ready}, 32'd0);

        // Velocity: one step every 20 clocks on channel 1
        cfg(1, 1, 0, 0, 0);
        repeat (30) quad_step(1, 1, 20);
        rd_reg(1, R_VEL, v);
        check_val("vel", v, VEL_DIV / 20);

        // Reset in the middle of an access
        idle(1);
        addr  = {24'd0, 4'd0, R_CNT, 2'b00};
        wstrb = 4'h0;
        valid = 1'b1;
        idle(1);
        check_val("mid_ack", {31'd0, ready}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("mid_ready", {31'd0, ready}, 32'd0);
        check_val("mid_rdata", rdata, 32'd0);
        valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mcnt[i] = '0; mmode[i] = 0; minv[i] = 0; men[i] = 0;
        end
        idle(20);
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                rd_reg(c, 2'(r), v);
                check_val("post_rst", v, 32'd0);
            end
        end

        // Randomized walk across channels with sub-threshold glitches
        for (int c = 0; c < 4; c++) begin
            cfg(c, $urandom_range(0, 3) != 0, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
            set_count(c, 8'($urandom));
        end
        for (int it = 0; it < 160; it++) begin
            int ch;
            int g;
            int len;
            ch = $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) begin
                g   = $urandom_range(0, 3);
                len = $urandom_range(1, DELAY - 1);
                b[g] = ~b[g];
                idle(len);
                b[g] = ~b[g];
                idle(8);
            end
            quad_step(ch, ($urandom_range(0, 1) != 0) ? 1 : -1, 10);
            if (it % 20 == 19) begin
                for (int c = 0; c < 4; c++) chk_count("rand_cnt", c);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
